sync_fifo_ctrl: RTL and testbench



---
 rtl/fifo_pkg.sv | 13 +
 rtl/sync_fifo_ctrl_if.sv | 36 +++
 rtl/fifo_mem.sv | 37 +++
 rtl/sync_fifo_ctrl.sv | 92 +++++++++
 tb/tb_sync_fifo_ctrl.sv | 226 ++++++++++++++++++++++
 5 files changed

// File: rtl/fifo_pkg.sv
// Shared defaults for the synchronous FIFO controller family.
package fifo_pkg;

    // Storage geometry defaults; FIFO_DEPTH must always equal 2**FIFO_ADDR.
    localparam int FIFO_WIDTH     = 38;
    localparam int FIFO_ADDR      = 10;
    localparam int FIFO_DEPTH     = 1 << FIFO_ADDR;

    // almost_full fires this many entries below full; almost_empty at or below this count.
    localparam int FIFO_AF_MARGIN = 4;
    localparam int FIFO_AE_LEVEL  = 4;

endpackage

// File: rtl/sync_fifo_ctrl_if.sv
// Request/response and status bundle between a FIFO user and sync_fifo_ctrl.
interface sync_fifo_ctrl_if
    import fifo_pkg::*;
#(
    parameter int WIDTH = FIFO_WIDTH,
    parameter int ADDR  = FIFO_ADDR
);

    logic             wr_en;
    logic [WIDTH-1:0] wr_data;
    logic             rd_en;
    logic [WIDTH-1:0] rd_data;
    logic             rd_valid;
    logic             full;
    logic             empty;
    logic             almost_full;
    logic             almost_empty;
    logic [ADDR:0]    count;
    logic             overflow;
    logic             underflow;

    // The user side issues requests and observes data and status.
    modport master (
        output wr_en, wr_data, rd_en,
        input  rd_data, rd_valid, full, empty, almost_full, almost_empty,
               count, overflow, underflow
    );

    // The FIFO side consumes requests and produces data and status.
    modport slave (
        input  wr_en, wr_data, rd_en,
        output rd_data, rd_valid, full, empty, almost_full, almost_empty,
               count, overflow, underflow
    );

endinterface

// File: rtl/fifo_mem.sv
// Simple dual-port memory with a registered read port.
module fifo_mem #(
    parameter int WIDTH = 8,
    parameter int ADDR  = 4
) (
    input  logic             wr_clk,
    input  logic             rd_clk,
    input  logic             rst_n,
    input  logic             wr_en,
    input  logic [ADDR-1:0]  wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    input  logic [ADDR-1:0]  rd_addr,
    output logic [WIDTH-1:0] rd_data
);

    localparam int DEPTH = 1 << ADDR;

    logic [WIDTH-1:0] mem [DEPTH];

    // Storage array is deliberately left out of reset so it maps onto RAM.
    always_ff @(posedge wr_clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Read register: loads only on a read, otherwise keeps the last word.
    always_ff @(posedge rd_clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data <= '0;
        end else if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/sync_fifo_ctrl.sv
// Single-clock FIFO controller: pointers, occupancy, registered status flags.
module sync_fifo_ctrl
    import fifo_pkg::*;
#(
    parameter int WIDTH    = FIFO_WIDTH,
    parameter int DEPTH    = FIFO_DEPTH,
    parameter int ADDR     = FIFO_ADDR,
    parameter int AF_LEVEL = DEPTH - FIFO_AF_MARGIN,
    parameter int AE_LEVEL = FIFO_AE_LEVEL
) (
    input  logic           clk,
    input  logic           rst_n,
    sync_fifo_ctrl_if.slave bus
);

    logic [ADDR-1:0] wr_ptr;
    logic [ADDR-1:0] rd_ptr;
    logic [ADDR:0]   count;
    logic [ADDR:0]   count_next;
    logic            full;
    logic            empty;
    logic            almost_full;
    logic            almost_empty;
    logic            rd_valid;
    logic            overflow;
    logic            underflow;
    logic            wr_acc;
    logic            rd_acc;

    // Acceptance uses the registered flags, so a full FIFO rejects a write even if a read frees a slot.
    always_comb begin
        wr_acc     = bus.wr_en && !full;
        rd_acc     = bus.rd_en && !empty;
        count_next = count + (ADDR + 1)'(wr_acc) - (ADDR + 1)'(rd_acc);
    end

    // Pointers, occupancy and flags all update together from the next count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            count        <= '0;
            full         <= 1'b0;
            empty        <= 1'b1;
            almost_full  <= 1'b0;
            almost_empty <= 1'b1;
            rd_valid     <= 1'b0;
            overflow     <= 1'b0;
            underflow    <= 1'b0;
        end else begin
            if (wr_acc) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (rd_acc) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            count        <= count_next;
            full         <= (count_next == (ADDR + 1)'(DEPTH));
            empty        <= (count_next == '0);
            almost_full  <= (count_next >= (ADDR + 1)'(AF_LEVEL));
            almost_empty <= (count_next <= (ADDR + 1)'(AE_LEVEL));
            rd_valid     <= rd_acc;
            overflow     <= bus.wr_en && full;
            underflow    <= bus.rd_en && empty;
        end
    end

    fifo_mem #(
        .WIDTH (WIDTH),
        .ADDR  (ADDR)
    ) u_mem (
        .wr_clk  (clk),
        .rd_clk  (clk),
        .rst_n   (rst_n),
        .wr_en   (wr_acc),
        .wr_addr (wr_ptr),
        .wr_data (bus.wr_data),
        .rd_en   (rd_acc),
        .rd_addr (rd_ptr),
        .rd_data (bus.rd_data)
    );

    assign bus.count        = count;
    assign bus.full         = full;
    assign bus.empty        = empty;
    assign bus.almost_full  = almost_full;
    assign bus.almost_empty = almost_empty;
    assign bus.rd_valid     = rd_valid;
    assign bus.overflow     = overflow;
    assign bus.underflow    = underflow;

endmodule

// File: tb/tb_sync_fifo_ctrl.sv
// Self-checking bench for sync_fifo_ctrl with a small FIFO configuration.
module tb_sync_fifo_ctrl;

    localparam int WIDTH    = 8;
    localparam int DEPTH    = 16;
    localparam int ADDR     = 4;
    localparam int AF_LEVEL = 12;
    localparam int AE_LEVEL = 4;

    logic clk;
    logic rst_n;

    sync_fifo_ctrl_if #(.WIDTH(WIDTH), .ADDR(ADDR)) bus ();

    sync_fifo_ctrl #(
        .WIDTH    (WIDTH),
        .DEPTH    (DEPTH),
        .ADDR     (ADDR),
        .AF_LEVEL (AF_LEVEL),
        .AE_LEVEL (AE_LEVEL)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit         wr;
        logic [7:0] wd;
        bit         rd;
        int         exp_count;
        bit         exp_empty;
        bit         exp_unf;
        bit         exp_valid;
        logic [7:0] exp_data;
    } vec_t;

    int total = 0;
    int bad   = 0;

    logic [7:0] model_q[$];
    logic [7:0] sb_q[$];
    bit         exp_ovf;
    bit         exp_unf;
    bit         exp_valid;
    logic [7:0] last_data;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Compare every output against the reference model after a clock edge.
    task automatic checkOutput();
        int n;
        n = model_q.size();
        check("count", 32'(bus.count), 32'(n));
        check("full", 32'(bus.full), 32'(n == DEPTH));
        check("empty", 32'(bus.empty), 32'(n == 0));
        check("almost_full", 32'(bus.almost_full), 32'(n >= AF_LEVEL));
        check("almost_empty", 32'(bus.almost_empty), 32'(n <= AE_LEVEL));
        check("overflow", 32'(bus.overflow), 32'(exp_ovf));
        check("underflow", 32'(bus.underflow), 32'(exp_unf));
        check("rd_valid", 32'(bus.rd_valid), 32'(exp_valid));
        check("rd_data_hold", 32'(bus.rd_data), 32'(last_data));
        if (bus.rd_valid === 1'b1) begin
            if (sb_q.size() == 0) begin
                check("scoreboard_underrun", 32'd1, 32'd0);
            end else begin
                check("scoreboard_data", 32'(bus.rd_data), 32'(sb_q.pop_front()));
            end
        end
    endtask

    // Drive one cycle of requests, update the model, then check after the edge.
    task automatic applyStimulus(input bit wr, input logic [7:0] wd, input bit rd);
        bit m_full;
        bit m_empty;
        bit wacc;
        bit racc;
        @(negedge clk);
        bus.wr_en   = wr;
        bus.wr_data = wd;
        bus.rd_en   = rd;
        m_full  = (model_q.size() == DEPTH);
        m_empty = (model_q.size() == 0);
        wacc    = wr && !m_full;
        racc    = rd && !m_empty;
        exp_ovf   = wr && m_full;
        exp_unf   = rd && m_empty;
        exp_valid = racc;
        if (racc) begin
            last_data = model_q.pop_front();
            sb_q.push_back(last_data);
        end
        if (wacc) begin
            model_q.push_back(wd);
        end
        @(posedge clk);
        #1;
        checkOutput();
        bus.wr_en = 1'b0;
        bus.rd_en = 1'b0;
    endtask

    // Assert reset between edges and check that outputs clear without a clock.
    task automatic doReset();
        @(negedge clk);
        bus.wr_en = 1'b0;
        bus.rd_en = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_count", 32'(bus.count), 32'd0);
        check("rst_full", 32'(bus.full), 32'd0);
        check("rst_empty", 32'(bus.empty), 32'd1);
        check("rst_almost_full", 32'(bus.almost_full), 32'd0);
        check("rst_almost_empty", 32'(bus.almost_empty), 32'd1);
        check("rst_rd_valid", 32'(bus.rd_valid), 32'd0);
        check("rst_rd_data", 32'(bus.rd_data), 32'd0);
        check("rst_overflow", 32'(bus.overflow), 32'd0);
        check("rst_underflow", 32'(bus.underflow), 32'd0);
        model_q.delete();
        sb_q.delete();
        exp_ovf   = 1'b0;
        exp_unf   = 1'b0;
        exp_valid = 1'b0;
        last_data = 8'h00;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    vec_t vecs[7];

    initial begin
        rst_n       = 1'b0;
        bus.wr_en   = 1'b0;
        bus.wr_data = '0;
        bus.rd_en   = 1'b0;
        exp_ovf     = 1'b0;
        exp_unf     = 1'b0;
        exp_valid   = 1'b0;
        last_data   = 8'h00;

        vecs[0] = '{wr: 0, wd: 8'h00, rd: 1, exp_count: 0, exp_empty: 1, exp_unf: 1, exp_valid: 0, exp_data: 8'h00};
        vecs[1] = '{wr: 1, wd: 8'h11, rd: 0, exp_count: 1, exp_empty: 0, exp_unf: 0, exp_valid: 0, exp_data: 8'h00};
        vecs[2] = '{wr: 1, wd: 8'h22, rd: 1, exp_count: 1, exp_empty: 0, exp_unf: 0, exp_valid: 1, exp_data: 8'h11};
        vecs[3] = '{wr: 0, wd: 8'h00, rd: 1, exp_count: 0, exp_empty: 1, exp_unf: 0, exp_valid: 1, exp_data: 8'h22};
        vecs[4] = '{wr: 0, wd: 8'h00, rd: 0, exp_count: 0, exp_empty: 1, exp_unf: 0, exp_valid: 0, exp_data: 8'h22};
        vecs[5] = '{wr: 1, wd: 8'h33, rd: 1, exp_count: 1, exp_empty: 0, exp_unf: 1, exp_valid: 0, exp_data: 8'h22};
        vecs[6] = '{wr: 0, wd: 8'h00, rd: 1, exp_count: 0, exp_empty: 1, exp_unf: 0, exp_valid: 1, exp_data: 8'h33};

        doReset();

        for (int i = 0; i < 7; i++) begin
            applyStimulus(vecs[i].wr, vecs[i].wd, vecs[i].rd);
            check("vec_count", 32'(bus.count), 32'(vecs[i].exp_count));
            check("vec_empty", 32'(bus.empty), 32'(vecs[i].exp_empty));
            check("vec_underflow", 32'(bus.underflow), 32'(vecs[i].exp_unf));
            check("vec_rd_valid", 32'(bus.rd_valid), 32'(vecs[i].exp_valid));
            check("vec_rd_data", 32'(bus.rd_data), 32'(vecs[i].exp_data));
        end

        // Fill from reset and watch the threshold flags move.
        doReset();
        for (int i = 0; i < 16; i++) begin
            applyStimulus(1'b1, 8'(i), 1'b0);
            if (i == 4) check("ae_at_5", 32'(bus.almost_empty), 32'd0);
            if (i == 10) check("af_at_11", 32'(bus.almost_full), 32'd0);
            if (i == 11) check("af_at_12", 32'(bus.almost_full), 32'd1);
        end
        check("fill_full", 32'(bus.full), 32'd1);
        check("fill_count", 32'(bus.count), 32'd16);

        // Write into a full FIFO, then drain and verify order.
        applyStimulus(1'b1, 8'hAA, 1'b0);
        check("ovf_pulse", 32'(bus.overflow), 32'd1);
        check("ovf_count", 32'(bus.count), 32'd16);
        applyStimulus(1'b0, 8'h00, 1'b0);
        check("ovf_single", 32'(bus.overflow), 32'd0);
        for (int i = 0; i < 16; i++) begin
            applyStimulus(1'b0, 8'h00, 1'b1);
            check("drain_data", 32'(bus.rd_data), 32'(i));
        end

        // Read from empty leaves the data register alone.
        applyStimulus(1'b0, 8'h00, 1'b1);
        check("unf_pulse", 32'(bus.underflow), 32'd1);
        check("unf_no_valid", 32'(bus.rd_valid), 32'd0);
        check("unf_data_held", 32'(bus.rd_data), 32'h0F);

        // Steady-state streaming at count 8 wraps the pointers.
        for (int i = 0; i < 8; i++) applyStimulus(1'b1, 8'(8'h40 + i), 1'b0);
        for (int i = 0; i < 40; i++) applyStimulus(1'b1, 8'(8'h80 + i), 1'b1);
        check("stream_count", 32'(bus.count), 32'd8);
        for (int i = 0; i < 8; i++) applyStimulus(1'b0, 8'h00, 1'b1);

        // Full with both requests: read wins, write is rejected.
        for (int i = 0; i < 16; i++) applyStimulus(1'b1, 8'(8'hC0 + i), 1'b0);
        applyStimulus(1'b1, 8'hEE, 1'b1);
        check("both_full_count", 32'(bus.count), 32'd15);
        check("both_full_ovf", 32'(bus.overflow), 32'd1);
        check("both_full_valid", 32'(bus.rd_valid), 32'd1);
        for (int i = 0; i < 6; i++) applyStimulus(1'b0, 8'h00, 1'b1);
        check("pre_reset_count", 32'(bus.count), 32'd9);

        // Reset in the middle of a burst, then a fresh write/read round trip.
        doReset();
        applyStimulus(1'b1, 8'h5C, 1'b0);
        applyStimulus(1'b0, 8'h00, 1'b1);
        check("post_reset_data", 32'(bus.rd_data), 32'h5C);
        check("post_reset_valid", 32'(bus.rd_valid), 32'd1);

        check("scoreboard_empty", 32'(sb_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
